pkt_wr_arbiter: RTL and testbench

PKT_WR_ARBITER -- requirements
Module: pkt_wr_arbiter

---
 rtl/pkt_arb_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/pkt_wr_arbiter.sv | 138 +++++++++++++
 tb/tb_pkt_wr_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_arb_pkg.sv
// Shared types and default sizing for the packet write-port arbiter.
package pkt_arb_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefNumReq    = 4;
    localparam int unsigned DefPktSize   = 10;

    typedef enum logic [0:0] {
        StIdle,
        StXfer
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or after ptr_i, wrapping.
module rr_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned PTR_W   = (DefNumReq > 1) ? $clog2(DefNumReq) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    // Walk the requesters starting at the pointer; the first hit wins.
    always_comb begin : l_search
        logic        found;
        int unsigned idx;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_wr_arbiter.sv
// Grants one requester at a time the FIFO write port for a whole fixed-size packet.
module pkt_wr_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned NUM_REQ    = DefNumReq,
    parameter int unsigned PKT_SIZE   = DefPktSize
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic                          full_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            ack_o,
    output logic                          w_inc_o,
    output logic [DATA_WIDTH-1:0]         wr_data_o,
    output logic                          last_o,
    output logic                          abort_o,
    output logic                          busy_o
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(PKT_SIZE);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [PtrW-1:0]     ptr_q, ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                abort_q, abort_d;

    logic [NUM_REQ-1:0]  rr_gnt;
    logic [PtrW-1:0]     gnt_idx;
    logic [PtrW-1:0]     ptr_next;
    logic                in_xfer;
    logic                req_granted;
    logic                w_inc;
    logic                last;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PtrW)
    ) u_rr_arbiter (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt)
    );

    // Encode the held one-hot grant and derive the pointer for the following packet.
    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                gnt_idx = PtrW'(i);
            end
        end
        ptr_next = (gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : gnt_idx + PtrW'(1);
    end

    assign in_xfer     = (state_q == StXfer);
    assign req_granted = |(req_i & gnt_q);
    assign w_inc       = in_xfer & ~full_i & req_granted;
    assign last        = w_inc & (cnt_q == CntW'(PKT_SIZE - 1));

    // Byte-lane mux; forced to zero outside a transfer.
    always_comb begin
        wr_data_o = '0;
        if (in_xfer) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (gnt_q[i]) begin
                    wr_data_o = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Next-state: grant on any request in idle, leave transfer on final byte or requester drop.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|req_i) begin
                    gnt_d   = rr_gnt;
                    cnt_d   = '0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (!req_granted) begin
                    // Dropped mid-packet: no write this cycle, pointer still moves on.
                    state_d = StIdle;
                    gnt_d   = '0;
                    ptr_d   = ptr_next;
                    abort_d = 1'b1;
                end else if (last) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    ptr_d   = ptr_next;
                    cnt_d   = '0;
                end else if (w_inc) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, grant, pointer, byte counter and abort pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign ack_o   = gnt_q & {NUM_REQ{w_inc}};
    assign w_inc_o = w_inc;
    assign last_o  = last;
    assign abort_o = abort_q;
    assign busy_o  = in_xfer;

endmodule

// File: tb/tb_pkt_wr_arbiter.sv
// Scoreboard bench for pkt_wr_arbiter: expected writes queued at stimulus, popped on each W_INC.
module tb_pkt_wr_arbiter;

    localparam int NReq = 4;
    localparam int Dw   = 8;
    localparam int Pkt  = 10;

    typedef struct {
        logic [Dw-1:0]   data;
        logic [NReq-1:0] ack;
        logic            last;
        logic            first;
    } exp_t;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [NReq-1:0]      req_i;
    logic [NReq*Dw-1:0]   req_data_i;
    logic                 full_i;
    logic [NReq-1:0]      gnt_o;
    logic [NReq-1:0]      ack_o;
    logic                 w_inc_o;
    logic [Dw-1:0]        wr_data_o;
    logic                 last_o;
    logic                 abort_o;
    logic                 busy_o;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_cyc = -1;
    int   wr_cnt = 0;
    int   abort_cnt = 0;
    bit   gap_chk = 1'b0;
    logic [NReq-1:0] ack_s;
    logic            last_s;

    int byte_idx[NReq];
    int pkt_no[NReq];
    int pkts_left[NReq];
    int drop_at[NReq];

    pkt_wr_arbiter #(
        .DATA_WIDTH (Dw),
        .NUM_REQ    (NReq),
        .PKT_SIZE   (Pkt)
    ) u_dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .req_data_i (req_data_i),
        .full_i     (full_i),
        .gnt_o      (gnt_o),
        .ack_o      (ack_o),
        .w_inc_o    (w_inc_o),
        .wr_data_o  (wr_data_o),
        .last_o     (last_o),
        .abort_o    (abort_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [Dw-1:0] lane_val(input int i, input int p, input int b);
        return Dw'(i * 64 + (p % 4) * 16 + b);
    endfunction

    task automatic drive_lanes();
        for (int i = 0; i < NReq; i++) begin
            req_i[i]               = (pkts_left[i] > 0);
            req_data_i[i*Dw +: Dw] = lane_val(i, pkt_no[i], byte_idx[i]);
        end
    endtask

    task automatic push_pkt(input int i, input int p, input int nbytes);
        exp_t e;
        for (int b = 0; b < nbytes; b++) begin
            e.data  = lane_val(i, p, b);
            e.ack   = NReq'(1 << i);
            e.last  = (b == Pkt - 1);
            e.first = (b == 0);
            q.push_back(e);
        end
    endtask

    // One clock: check outputs at the falling edge, then update the requester model after the rise.
    task automatic tick();
        exp_t e;
        @(negedge clk_i);
        cyc++;
        ack_s  = ack_o;
        last_s = last_o;
        if (abort_o) abort_cnt++;
        if (w_inc_o) begin
            wr_cnt++;
            if (q.size() == 0) begin
                check_eq("write_with_empty_queue", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                check_eq("wr_data", 32'(wr_data_o), 32'(e.data));
                check_eq("ack", 32'(ack_o), 32'(e.ack));
                check_eq("last", 32'(last_o), 32'(e.last));
                if (gap_chk && e.first && last_cyc >= 0) begin
                    check_eq("pkt_gap", 32'(cyc - last_cyc), 32'd2);
                end
                if (e.last) last_cyc = cyc;
            end
        end
        @(posedge clk_i);
        #1;
        for (int i = 0; i < NReq; i++) begin
            if (ack_s[i]) begin
                if (last_s) begin
                    byte_idx[i] = 0;
                    pkt_no[i]++;
                    pkts_left[i]--;
                end else begin
                    byte_idx[i]++;
                end
            end
            if (drop_at[i] >= 0 && byte_idx[i] == drop_at[i] && pkts_left[i] > 0) begin
                pkts_left[i]--;
                pkt_no[i]++;
                byte_idx[i] = 0;
                drop_at[i]  = -1;
            end
        end
        drive_lanes();
    endtask

    task automatic drain(input string tag, input int max_cycles);
        for (int k = 0; k < max_cycles && q.size() != 0; k++) tick();
        check_eq(tag, 32'(q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, 32'({gnt_o, ack_o, w_inc_o, last_o, abort_o, busy_o, wr_data_o}), 32'd0);
    endtask

    initial begin
        int wc0;
        for (int i = 0; i < NReq; i++) begin
            byte_idx[i]  = 0;
            pkt_no[i]    = 0;
            pkts_left[i] = 0;
            drop_at[i]   = -1;
        end
        rst_ni = 1'b0;
        full_i = 1'b0;
        drive_lanes();
        repeat (3) tick();
        check_all_zero("reset_outputs");
        rst_ni = 1'b1;
        tick();

        // Contention: all four request, requester 0 has two packets -> 0,1,2,3,0.
        pkts_left[0] = 2; pkts_left[1] = 1; pkts_left[2] = 1; pkts_left[3] = 1;
        push_pkt(0, 0, Pkt); push_pkt(1, 0, Pkt); push_pkt(2, 0, Pkt);
        push_pkt(3, 0, Pkt); push_pkt(0, 1, Pkt);
        gap_chk = 1'b1; last_cyc = -1;
        drive_lanes();
        drain("contention_drain", 120);
        gap_chk = 1'b0;
        repeat (2) tick();

        // Single requester: grant one cycle after request, ten writes, grant clears.
        pkts_left[0] = 1;
        push_pkt(0, pkt_no[0], Pkt);
        drive_lanes();
        tick();
        check_eq("single_gnt", 32'(gnt_o), 32'h1);
        check_eq("single_busy", 32'(busy_o), 32'd1);
        wc0 = wr_cnt;
        drain("single_drain", 30);
        check_eq("single_nwrites", 32'(wr_cnt - wc0), 32'(Pkt));
        check_eq("single_gnt_clear", 32'(gnt_o), 32'h0);
        check_eq("single_busy_clear", 32'(busy_o), 32'd0);
        repeat (2) tick();

        // Abort: requester 1 drops after six bytes; pointer moves to 2 ahead of 0.
        pkts_left[0] = 1; pkts_left[1] = 1; pkts_left[2] = 1;
        drop_at[1] = 6;
        push_pkt(1, pkt_no[1], 6); push_pkt(2, pkt_no[2], Pkt); push_pkt(0, pkt_no[0], Pkt);
        drive_lanes();
        drain("abort_drain", 80);
        repeat (2) tick();
        check_eq("abort_pulses", 32'(abort_cnt), 32'd1);

        // Backpressure: FULL for three cycles after byte 4.
        pkts_left[2] = 1;
        push_pkt(2, pkt_no[2], Pkt);
        drive_lanes();
        for (int k = 0; k < 30 && byte_idx[2] != 4; k++) tick();
        check_eq("bp_reach_byte4", 32'(byte_idx[2]), 32'd4);
        full_i = 1'b1;
        wc0 = wr_cnt;
        repeat (3) tick();
        check_eq("bp_no_writes", 32'(wr_cnt - wc0), 32'd0);
        full_i = 1'b0;
        drain("bp_drain", 30);
        check_eq("bp_total_writes", 32'(wr_cnt - wc0), 32'd6);
        repeat (2) tick();

        // Entry stall: FULL already high at grant, released five cycles later.
        full_i = 1'b1;
        pkts_left[3] = 1;
        push_pkt(3, pkt_no[3], Pkt);
        drive_lanes();
        tick();
        check_eq("stall_gnt", 32'(gnt_o), 32'h8);
        wc0 = wr_cnt;
        repeat (4) tick();
        check_eq("stall_no_writes", 32'(wr_cnt - wc0), 32'd0);
        full_i = 1'b0;
        #1;
        check_eq("stall_winc_on_release", 32'(w_inc_o), 32'd1);
        drain("stall_drain", 30);
        repeat (2) tick();

        // Requester 1 completes so the pointer sits at 2 before the reset test.
        pkts_left[1] = 1;
        push_pkt(1, pkt_no[1], Pkt);
        drive_lanes();
        drain("pre_reset_drain", 30);
        repeat (2) tick();

        // Reset during byte 5 of requester 2, then 1010 must grant requester 1 first.
        pkts_left[2] = 1;
        push_pkt(2, pkt_no[2], 5);
        drive_lanes();
        for (int k = 0; k < 30 && byte_idx[2] != 5; k++) tick();
        check_eq("rst_reach_byte5", 32'(byte_idx[2]), 32'd5);
        check_eq("rst_winc_before", 32'(w_inc_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check_all_zero("rst_async_outputs");
        check_eq("rst_queue_empty", 32'(q.size()), 32'd0);
        pkts_left[2] = 0; byte_idx[2] = 0; pkt_no[2]++;
        pkts_left[1] = 1; pkts_left[3] = 1;
        drive_lanes();
        repeat (2) tick();
        check_all_zero("rst_held_outputs");
        push_pkt(1, pkt_no[1], Pkt); push_pkt(3, pkt_no[3], Pkt);
        gap_chk = 1'b1; last_cyc = -1;
        rst_ni = 1'b1;
        tick();
        check_eq("rst_first_gnt", 32'(gnt_o), 32'h2);
        drain("rst_drain", 60);
        gap_chk = 1'b0;
        repeat (3) tick();
        check_eq("rst_no_abort", 32'(abort_cnt), 32'd1);
        check_eq("final_queue", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
